// File: rtl/alu_wb_queue_if.sv
// Handshake bundle between the ALU, the branch unit and the writeback/bypass port.
interface alu_wb_queue_if #(
    parameter int DATA_W  = 32,
    parameter int FLAGS_W = 6,
    parameter int PREG_W  = 7,
    parameter int ROB_W   = 7,
    parameter int BMASK_W = 4
) ();
    logic               in_valid_i;
    logic               in_ready_o;
    logic [DATA_W-1:0]  result_i;
    logic [FLAGS_W-1:0] flags_i;
    logic [PREG_W-1:0]  pdest_i;
    logic               dest_valid_i;
    logic [ROB_W-1:0]   rob_id_i;
    logic [BMASK_W-1:0] bmask_i;
    logic               ctrl_valid_i;
    logic               ctrl_mispredict_i;
    logic [BMASK_W-1:0] ctrl_tag_i;
    logic               flush_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [DATA_W-1:0]  out_data_o;
    logic [FLAGS_W-1:0] out_flags_o;
    logic [PREG_W-1:0]  out_pdest_o;
    logic               out_dest_valid_o;
    logic [ROB_W-1:0]   out_rob_id_o;
    logic [BMASK_W-1:0] out_bmask_o;
    logic               bypass_valid_o;
    logic [PREG_W-1:0]  bypass_tag_o;
    logic [DATA_W-1:0]  bypass_data_o;

    modport slave (
        input  in_valid_i, result_i, flags_i, pdest_i, dest_valid_i, rob_id_i, bmask_i,
        input  ctrl_valid_i, ctrl_mispredict_i, ctrl_tag_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_flags_o, out_pdest_o,
        output out_dest_valid_o, out_rob_id_o, out_bmask_o,
        output bypass_valid_o, bypass_tag_o, bypass_data_o
    );

    modport master (
        output in_valid_i, result_i, flags_i, pdest_i, dest_valid_i, rob_id_i, bmask_i,
        output ctrl_valid_i, ctrl_mispredict_i, ctrl_tag_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_flags_o, out_pdest_o,
        input  out_dest_valid_o, out_rob_id_o, out_bmask_o,
        input  bypass_valid_o, bypass_tag_o, bypass_data_o
    );
endinterface

// File: rtl/alu_wb_queue.sv
// In-order execute-to-writeback queue with branch-mask squashing.
// Optional ALU_WB_SKID_BYPASS_EN: forward straight to writeback when the queue is empty.
module alu_wb_queue #(
    parameter int DATA_W  = 32,
    parameter int FLAGS_W = 6,
    parameter int PREG_W  = 7,
    parameter int ROB_W   = 7,
    parameter int BMASK_W = 4,
    parameter int DEPTH   = 2
) (
    input  logic          clk,
    input  logic          reset,
    alu_wb_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic               occ;
        logic               live;
        logic [DATA_W-1:0]  data;
        logic [FLAGS_W-1:0] flags;
        logic [PREG_W-1:0]  pdest;
        logic               dest_valid;
        logic [ROB_W-1:0]   rob_id;
        logic [BMASK_W-1:0] bmask;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    entry_t             head_e_s;
    entry_t             in_e_s;
    logic               resolve_s;
    logic               mispred_s;
    logic               kill_head_s;
    logic               in_kill_s;
    logic               in_ready_s;
    logic               head_valid_s;
    logic               skid_s;
    logic               enq_s;
    logic               pop_s;
    logic               out_valid_s;
    logic               out_dv_s;

    // Handshake decisions derived from registered state and this cycle's events
    always_comb begin
        head_e_s     = mem_q[head_q];
        resolve_s    = bus.ctrl_valid_i & ~bus.ctrl_mispredict_i;
        mispred_s    = bus.ctrl_valid_i & bus.ctrl_mispredict_i;
        kill_head_s  = mispred_s & (|(head_e_s.bmask & bus.ctrl_tag_i));
        in_kill_s    = mispred_s & (|(bus.bmask_i & bus.ctrl_tag_i));
        in_ready_s   = (count_q < CNT_W'(DEPTH)) & ~bus.flush_i;
        head_valid_s = head_e_s.occ & head_e_s.live & ~kill_head_s & ~bus.flush_i;

        in_e_s.occ        = 1'b1;
        in_e_s.live       = ~in_kill_s;
        in_e_s.data       = bus.result_i;
        in_e_s.flags      = bus.flags_i;
        in_e_s.pdest      = bus.pdest_i;
        in_e_s.dest_valid = bus.dest_valid_i;
        in_e_s.rob_id     = bus.rob_id_i;
        if (bus.ctrl_valid_i) begin
            in_e_s.bmask = bus.bmask_i & ~bus.ctrl_tag_i;
        end else begin
            in_e_s.bmask = bus.bmask_i;
        end

`ifdef ALU_WB_SKID_BYPASS_EN
        skid_s = (count_q == CNT_W'(0)) & bus.out_ready_i & bus.in_valid_i &
                 ~in_kill_s & ~bus.flush_i;
`else
        skid_s = 1'b0;
`endif

        enq_s = bus.in_valid_i & in_ready_s & ~skid_s;
        // Dead or just-killed heads drain without waiting for the consumer
        pop_s = ~bus.flush_i & head_e_s.occ &
                ((head_valid_s & bus.out_ready_i) | ~head_e_s.live | kill_head_s);
    end

    // Writeback and bypass port drive, from the head or the skid path
    always_comb begin
        bus.in_ready_o = in_ready_s;
        if (skid_s) begin
            out_valid_s          = 1'b1;
            out_dv_s             = in_e_s.dest_valid;
            bus.out_data_o       = in_e_s.data;
            bus.out_flags_o      = in_e_s.flags;
            bus.out_pdest_o      = in_e_s.pdest;
            bus.out_rob_id_o     = in_e_s.rob_id;
            bus.out_bmask_o      = in_e_s.bmask;
        end else begin
            out_valid_s          = head_valid_s;
            out_dv_s             = head_e_s.dest_valid;
            bus.out_data_o       = head_e_s.data;
            bus.out_flags_o      = head_e_s.flags;
            bus.out_pdest_o      = head_e_s.pdest;
            bus.out_rob_id_o     = head_e_s.rob_id;
            if (bus.ctrl_valid_i) begin
                bus.out_bmask_o  = head_e_s.bmask & ~bus.ctrl_tag_i;
            end else begin
                bus.out_bmask_o  = head_e_s.bmask;
            end
        end
        bus.out_valid_o      = out_valid_s;
        bus.out_dest_valid_o = out_dv_s;
        bus.bypass_valid_o   = out_valid_s & bus.out_ready_i & out_dv_s;
        bus.bypass_tag_o     = bus.out_pdest_o;
        bus.bypass_data_o    = bus.out_data_o;
    end

    // Next queue state: flush, branch resolution, pop, then enqueue
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i].occ = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_q[i].occ && resolve_s) begin
                    mem_d[i].bmask = mem_q[i].bmask & ~bus.ctrl_tag_i;
                end else if (mem_q[i].occ && mispred_s && (|(mem_q[i].bmask & bus.ctrl_tag_i))) begin
                    mem_d[i].live = 1'b0;
                end else begin
                    mem_d[i] = mem_q[i];
                end
            end
            if (pop_s) begin
                mem_d[head_q].occ = 1'b0;
                head_d            = head_q + PTR_W'(1);
            end else begin
                head_d = head_q;
            end
            if (enq_s) begin
                mem_d[tail_q] = in_e_s;
                tail_d        = tail_q + PTR_W'(1);
            end else begin
                tail_d = tail_q;
            end
            count_d = count_q + CNT_W'(enq_s) - CNT_W'(pop_s);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_alu_wb_queue.sv
// Directed and randomized bench for alu_wb_queue against a queue-based reference model.
module tb_alu_wb_queue;
    localparam int DATA_W  = 32;
    localparam int FLAGS_W = 6;
    localparam int PREG_W  = 7;
    localparam int ROB_W   = 7;
    localparam int BMASK_W = 4;
    localparam int DEPTH   = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_wb_queue_if #(.DATA_W(DATA_W), .FLAGS_W(FLAGS_W), .PREG_W(PREG_W),
                      .ROB_W(ROB_W), .BMASK_W(BMASK_W)) bus ();

    alu_wb_queue #(.DATA_W(DATA_W), .FLAGS_W(FLAGS_W), .PREG_W(PREG_W), .ROB_W(ROB_W),
                   .BMASK_W(BMASK_W), .DEPTH(DEPTH)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic               live;
        logic [DATA_W-1:0]  data;
        logic [FLAGS_W-1:0] flags;
        logic [PREG_W-1:0]  pdest;
        logic               dv;
        logic [ROB_W-1:0]   rob;
        logic [BMASK_W-1:0] bmask;
    } ent_t;

    ent_t mq[$];
    ent_t m_new;
    logic m_pop, m_enq, m_skid;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [DATA_W-1:0] d, input logic [PREG_W-1:0] pd,
                          input logic dv, input logic [BMASK_W-1:0] bm);
        bus.in_valid_i   = v;
        bus.result_i     = d;
        bus.flags_i      = d[FLAGS_W-1:0];
        bus.pdest_i      = pd;
        bus.dest_valid_i = dv;
        bus.rob_id_i     = d[ROB_W+7:8];
        bus.bmask_i      = bm;
    endtask

    task automatic set_ctrl(input logic cv, input logic mis, input logic [BMASK_W-1:0] tag);
        bus.ctrl_valid_i      = cv;
        bus.ctrl_mispredict_i = mis;
        bus.ctrl_tag_i        = tag;
    endtask

    // Compare outputs at the falling edge against the model and decide this cycle's events
    task automatic check_cycle();
        ent_t h;
        logic has, kill, in_dead, exp_ready, exp_valid, exp_byp;
        logic [BMASK_W-1:0] exp_bm;
        @(negedge clk);
        m_pop = 1'b0;
        m_enq = 1'b0;
        m_skid = 1'b0;
        if (reset) return;
        has = (mq.size() != 0);
        h = has ? mq[0] : '{default: '0};
        kill = has && bus.ctrl_valid_i && bus.ctrl_mispredict_i && ((h.bmask & bus.ctrl_tag_i) != '0);
        in_dead = bus.ctrl_valid_i && bus.ctrl_mispredict_i && ((bus.bmask_i & bus.ctrl_tag_i) != '0);
        exp_ready = (mq.size() < DEPTH) && !bus.flush_i;
        exp_valid = has && h.live && !kill && !bus.flush_i;
        m_new.live  = !in_dead;
        m_new.data  = bus.result_i;
        m_new.flags = bus.flags_i;
        m_new.pdest = bus.pdest_i;
        m_new.dv    = bus.dest_valid_i;
        m_new.rob   = bus.rob_id_i;
        m_new.bmask = bus.ctrl_valid_i ? (bus.bmask_i & ~bus.ctrl_tag_i) : bus.bmask_i;
`ifdef ALU_WB_SKID_BYPASS_EN
        m_skid = !has && bus.out_ready_i && bus.in_valid_i && !in_dead && !bus.flush_i;
`endif
        if (m_skid) begin
            exp_valid = 1'b1;
            h = m_new;
        end
        exp_bm  = bus.ctrl_valid_i ? (h.bmask & ~bus.ctrl_tag_i) : h.bmask;
        exp_byp = exp_valid && bus.out_ready_i && h.dv;
        chk("in_ready", 64'(bus.in_ready_o), 64'(exp_ready));
        chk("out_valid", 64'(bus.out_valid_o), 64'(exp_valid));
        chk("bypass_valid", 64'(bus.bypass_valid_o), 64'(exp_byp));
        if (exp_valid) begin
            chk("out_data", 64'(bus.out_data_o), 64'(h.data));
            chk("out_flags", 64'(bus.out_flags_o), 64'(h.flags));
            chk("out_pdest", 64'(bus.out_pdest_o), 64'(h.pdest));
            chk("out_dest_valid", 64'(bus.out_dest_valid_o), 64'(h.dv));
            chk("out_rob_id", 64'(bus.out_rob_id_o), 64'(h.rob));
            chk("out_bmask", 64'(bus.out_bmask_o), 64'(exp_bm));
        end
        if (exp_byp) begin
            chk("bypass_tag", 64'(bus.bypass_tag_o), 64'(h.pdest));
            chk("bypass_data", 64'(bus.bypass_data_o), 64'(h.data));
        end
        m_pop = !bus.flush_i && has && ((exp_valid && bus.out_ready_i) || !h.live || kill);
        m_enq = bus.in_valid_i && exp_ready && !m_skid;
    endtask

    // Advance the model by one clock and step to just after the rising edge
    task automatic tick();
        if (reset || bus.flush_i) begin
            mq.delete();
        end else begin
            if (m_pop) void'(mq.pop_front());
            foreach (mq[i]) begin
                if (bus.ctrl_valid_i && !bus.ctrl_mispredict_i)
                    mq[i].bmask = mq[i].bmask & ~bus.ctrl_tag_i;
                else if (bus.ctrl_valid_i && ((mq[i].bmask & bus.ctrl_tag_i) != '0))
                    mq[i].live = 1'b0;
            end
            if (m_enq) mq.push_back(m_new);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        check_cycle();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        set_in(1'b0, 32'h0, 7'd0, 1'b0, 4'b0000);
        set_ctrl(1'b0, 1'b0, 4'b0000);
        bus.flush_i     = 1'b0;
        bus.out_ready_i = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;

        // Reset state
        check_cycle();
        chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
        chk("rst_bypass_valid", 64'(bus.bypass_valid_o), 64'd0);
        chk("rst_out_data", 64'(bus.out_data_o), 64'd0);
        chk("rst_out_pdest", 64'(bus.out_pdest_o), 64'd0);
        chk("rst_out_bmask", 64'(bus.out_bmask_o), 64'd0);
        tick();

        // Single enqueue, one-cycle latency, bypass broadcast
        bus.out_ready_i = 1'b1;
        set_in(1'b1, 32'h0000_1234, 7'd5, 1'b1, 4'b0000);
        check_cycle();
        chk("t1_no_passthru", 64'(bus.out_valid_o), 64'd0);
        tick();
        set_in(1'b0, 32'h0, 7'd0, 1'b0, 4'b0000);
        check_cycle();
        chk("t1_out_valid", 64'(bus.out_valid_o), 64'd1);
        chk("t1_out_data", 64'(bus.out_data_o), 64'h1234);
        chk("t1_bypass_valid", 64'(bus.bypass_valid_o), 64'd1);
        chk("t1_bypass_tag", 64'(bus.bypass_tag_o), 64'd5);
        tick();
        check_cycle();
        chk("t1_drained", 64'(bus.out_valid_o), 64'd0);
        tick();

        // Back-pressure: fill to DEPTH, then drain in order
        bus.out_ready_i = 1'b0;
        set_in(1'b1, 32'h1111_0001, 7'd1, 1'b1, 4'b0000); cyc();
        set_in(1'b1, 32'h1111_0002, 7'd2, 1'b1, 4'b0000); cyc();
        set_in(1'b1, 32'h1111_0003, 7'd3, 1'b1, 4'b0000);
        check_cycle();
        chk("t2_full_ready", 64'(bus.in_ready_o), 64'd0);
        tick();
        set_in(1'b0, 32'h0, 7'd0, 1'b0, 4'b0000);
        bus.out_ready_i = 1'b1;
        check_cycle();
        chk("t2_first", 64'(bus.out_data_o), 64'h1111_0001);
        chk("t2_ready_lag", 64'(bus.in_ready_o), 64'd0);
        tick();
        check_cycle();
        chk("t2_second", 64'(bus.out_data_o), 64'h1111_0002);
        chk("t2_ready_back", 64'(bus.in_ready_o), 64'd1);
        tick();
        cyc();

        // Mispredict squashes A, B follows
        bus.out_ready_i = 1'b0;
        set_in(1'b1, 32'hAAAA_0000, 7'd10, 1'b1, 4'b0010); cyc();
        set_in(1'b1, 32'hBBBB_0000, 7'd11, 1'b1, 4'b0000); cyc();
        set_in(1'b0, 32'h0, 7'd0, 1'b0, 4'b0000);
        bus.out_ready_i = 1'b1;
        set_ctrl(1'b1, 1'b1, 4'b0010);
        check_cycle();
        chk("t3_killed", 64'(bus.out_valid_o), 64'd0);
        tick();
        set_ctrl(1'b0, 1'b0, 4'b0000);
        check_cycle();
        chk("t3_b_valid", 64'(bus.out_valid_o), 64'd1);
        chk("t3_b_data", 64'(bus.out_data_o), 64'hBBBB_0000);
        tick();
        cyc();

        // Correct prediction clears the mask bit
        bus.out_ready_i = 1'b0;
        set_in(1'b1, 32'hAAAA_0001, 7'd12, 1'b1, 4'b0010); cyc();
        set_in(1'b1, 32'hBBBB_0001, 7'd13, 1'b0, 4'b0000); cyc();
        set_in(1'b0, 32'h0, 7'd0, 1'b0, 4'b0000);
        set_ctrl(1'b1, 1'b0, 4'b0010);
        check_cycle();
        chk("t4_a_bmask", 64'(bus.out_bmask_o), 64'd0);
        tick();
        set_ctrl(1'b0, 1'b0, 4'b0000);
        bus.out_ready_i = 1'b1;
        check_cycle();
        chk("t4_a_data", 64'(bus.out_data_o), 64'hAAAA_0001);
        chk("t4_a_bmask_kept", 64'(bus.out_bmask_o), 64'd0);
        tick();
        cyc();
        cyc();

        // Flush while full with a pending enqueue
        bus.out_ready_i = 1'b0;
        set_in(1'b1, 32'hC0C0_0001, 7'd20, 1'b1, 4'b0000); cyc();
        set_in(1'b1, 32'hC0C0_0002, 7'd21, 1'b1, 4'b0000); cyc();
        set_in(1'b1, 32'hC0C0_0003, 7'd22, 1'b1, 4'b0000);
        bus.flush_i = 1'b1;
        check_cycle();
        chk("t5_flush_valid", 64'(bus.out_valid_o), 64'd0);
        tick();
        bus.flush_i = 1'b0;
        set_in(1'b0, 32'h0, 7'd0, 1'b0, 4'b0000);
        check_cycle();
        chk("t5_after_ready", 64'(bus.in_ready_o), 64'd1);
        chk("t5_after_valid", 64'(bus.out_valid_o), 64'd0);
        tick();

        // Reset while full
        set_in(1'b1, 32'hD0D0_0001, 7'd30, 1'b1, 4'b0000); cyc();
        set_in(1'b1, 32'hD0D0_0002, 7'd31, 1'b1, 4'b0000); cyc();
        set_in(1'b0, 32'h0, 7'd0, 1'b0, 4'b0000);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check_cycle();
        chk("t6_valid", 64'(bus.out_valid_o), 64'd0);
        chk("t6_ready", 64'(bus.in_ready_o), 64'd1);
        tick();
        bus.out_ready_i = 1'b1;
        set_in(1'b1, 32'hE0E0_0001, 7'd40, 1'b1, 4'b0000); cyc();
        set_in(1'b0, 32'h0, 7'd0, 1'b0, 4'b0000);
        check_cycle();
        chk("t6_reenq_data", 64'(bus.out_data_o), 64'hE0E0_0001);
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            bus.in_valid_i        = ($urandom_range(0, 9) < 6);
            bus.result_i          = $urandom;
            bus.flags_i           = FLAGS_W'($urandom);
            bus.pdest_i           = PREG_W'($urandom);
            bus.dest_valid_i      = 1'($urandom);
            bus.rob_id_i          = ROB_W'($urandom);
            bus.bmask_i           = BMASK_W'($urandom);
            bus.out_ready_i       = ($urandom_range(0, 3) != 0);
            bus.ctrl_valid_i      = ($urandom_range(0, 4) == 0);
            bus.ctrl_mispredict_i = 1'($urandom_range(0, 1));
            bus.ctrl_tag_i        = BMASK_W'(1) << $urandom_range(0, BMASK_W - 1);
            bus.flush_i           = ($urandom_range(0, 31) == 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
